conv_window_streamer: RTL and testbench
=======================================

Name: conv_window_streamer

Overview:
- Parametrised successor to the conv-layer input interface.
- Fetches a CH x IMG_H x IMG_W feature map from an asynchronous-read ROM/RAM and keeps K rows in a register line buffer.
- Streams kernel-tap slices to OUT_W parallel PEs, with OUT_W = IMG_W-K+1: one tap (i,j) per handshake, covering every output row of every channel.
- Adds valid/ready backpressure, enable freeze, multi-channel sequencing, tap/row/channel tags and a done pulse.

Parameters:
DATA_W, 32, pixel width in bits
IMG_W, 8, image width in pixels (>= K)
IMG_H, 8, image height in pixels (>= K)
K, 3, square kernel size (stride is fixed at 1)
CH, 1, channels processed sequentially
ADDR_W, 6, memory address width; must satisfy 2^ADDR_W >= CH*IMG_H*IMG_W
(derived localparams: OUT_W = IMG_W-K+1; OUT_H = IMG_H-K+1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
enable  in  1  level; 0 freezes all state
start  in  1  one-cycle pulse; begins a frame when idle
pixel_in  in  DATA_W  memory read data, combinational from rom_addr in the same cycle
rom_addr  out  ADDR_W  registered memory address
out_kernel_port  out  OUT_W*DATA_W  PE p slice = pixel[ch][r+i][p+j]; PE 0 in the MSB slice
out_valid  out  1  slice valid
out_ready  in  1  downstream accepts the slice
out_tap  out  clog2(K*K)  tap index i*K+j
out_row  out  clog2(OUT_H)  output row r
out_ch  out  clog2(CH) (min 1)  channel
out_last  out  1  final tap of the final row of the final channel
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset (rst_n=0 at an edge): IDLE; all outputs 0; line buffer contents don't-care. Reset mid-operation aborts immediately, with no done pulse.
- Address mapping: addr = ch*IMG_H*IMG_W + row*IMG_W + col. Each capture cycle stores pixel_in at the edge, then rom_addr increments.
- Handshake definition: a handshake is an edge where out_valid=1, out_ready=1 and enable=1.

State machine:
- IDLE: start=1 & enable=1 -> LOAD, with rom_addr = channel base (0). start is ignored when not IDLE.
- LOAD: K*IMG_W capture cycles fill buffer rows 0..K-1 in row-major order, then -> EMIT with tap 0. out_valid is high in the first EMIT cycle, i.e. K*IMG_W cycles after the start edge (24 at defaults).
- EMIT: out_valid=1. Data and tags stay stable until a handshake. A handshake advances the tap (j inner, i outer).
- EMIT, handshake on tap K*K-1:
  - if row < OUT_H-1: buffer rows shift up (row n <= row n+1), row++ -> SHIFT.
  - else if ch < CH-1: ch++, row=0 -> LOAD at the next channel base.
  - else -> DONE.
- SHIFT: IMG_W capture cycles overwrite buffer row K-1 with image row row+K-1, then -> EMIT with tap 0. out_valid=0 throughout.
- DONE: done=1 for one cycle -> IDLE. busy=0 from IDLE onwards.

Boundary and control rules:
- enable=0 in any state: no capture, no address change, no state change, handshake not accepted; outputs hold their values (out_valid stays at its current value).
- out_ready is ignored when out_valid=0.
- out_last = out_valid & last channel & last row & last tap.
- K=IMG_W (OUT_W=1) and K=IMG_H (OUT_H=1, no SHIFT) must both work.
- Cycle count (CH=1, out_ready=1, enable=1), start edge to done: K*IMG_W + OUT_H*K*K + (OUT_H-1)*IMG_W + 1 = 119 at defaults.

Test Plan:
All scenarios use defaults and memory contents where pixel = address, unless noted.
1. Reset then start, out_ready=1 -> first out_valid 24 cycles after start; slices read MSB first.
   - tap 0 = 0,1,2,3,4,5
   - tap 5 (1,2) = 10..15
   - row 1, tap 8 = 26..31
   - final slice = 58..63 with out_last=1, out_row=5
   - done pulses 119 cycles after start; 54 handshakes total.
2. Backpressure: hold out_ready=0 for 5 cycles while tap 4 is valid -> slice 9..14 and tags stay stable; no skipped or duplicated taps; done is delayed by exactly 5 cycles.
3. Enable freeze: enable=0 for 3 cycles in mid-LOAD (rom_addr=10) -> rom_addr holds 10; first slice is still 0..5, delayed by 3 cycles. enable=0 during EMIT with out_ready=1 -> no handshake occurs.
4. Multichannel, CH=2, ADDR_W=7 -> channel 1 tap 0 = 64..69 with out_ch=1, row=0; out_last only on 122..127; 108 handshakes; one done pulse.
5. Reset mid-EMIT (row 2), then start -> after the reset edge all outputs are 0, busy=0, no done; the new frame restarts at tap 0 = 0..5.
6. Corner configuration, K=IMG_W=IMG_H=3 -> one-pixel slices 0..8 in order; out_last on 8; no SHIFT state entered; a start pulse while busy is ignored.

Source files
------------

// File: rtl/conv_window_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_window_streamer: line-buffered KxK tap streamer feeding OUT_W PEs    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module conv_window_streamer #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int CH     = 1,
    parameter int ADDR_W = 6,
    localparam int OUT_W = IMG_W - K + 1,
    localparam int OUT_H = IMG_H - K + 1,
    localparam int TAP_W = (K * K > 1) ? $clog2(K * K) : 1,
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    start,
    input  logic [DATA_W-1:0]       pixel_in,
    output logic [ADDR_W-1:0]       rom_addr,
    output logic [OUT_W*DATA_W-1:0] out_kernel_port,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [TAP_W-1:0]        out_tap,
    output logic [ROW_W-1:0]        out_row,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int KI_W  = (K > 1) ? $clog2(K) : 1;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EMIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [KI_W-1:0]     lrow_q, lrow_d;
    logic [KI_W-1:0]     ti_q, ti_d;
    logic [KI_W-1:0]     tj_q, tj_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                done_q, done_d;
    logic                shift_up;
    logic [DATA_W-1:0]   line_q [K][IMG_W];

    logic col_end, last_tap, last_row, last_ch, capture;
    logic [KI_W-1:0] wr_row;

    assign col_end  = (col_q == COL_W'(IMG_W - 1));
    assign last_tap = (ti_q == KI_W'(K - 1)) && (tj_q == KI_W'(K - 1));
    assign last_row = (row_q == ROW_W'(OUT_H - 1));
    assign last_ch  = (ch_q == CH_W'(CH - 1));
    assign capture  = (state_q == S_LOAD) || (state_q == S_SHIFT);
    // SHIFT always refills the bottom row; LOAD walks all K rows in order
    assign wr_row   = (state_q == S_SHIFT) ? KI_W'(K - 1) : lrow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            col_q   <= '0;
            lrow_q  <= '0;
            ti_q    <= '0;
            tj_q    <= '0;
            row_q   <= '0;
            ch_q    <= '0;
            done_q  <= 1'b0;
        end else if (enable) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            lrow_q  <= lrow_d;
            ti_q    <= ti_d;
            tj_q    <= tj_d;
            row_q   <= row_d;
            ch_q    <= ch_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        col_d    = col_q;
        lrow_d   = lrow_q;
        ti_d     = ti_q;
        tj_d     = tj_q;
        row_d    = row_q;
        ch_d     = ch_q;
        done_d   = (state_q == S_DONE);
        shift_up = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    col_d   = '0;
                    lrow_d  = '0;
                    ti_d    = '0;
                    tj_d    = '0;
                    row_d   = '0;
                    ch_d    = '0;
                end
            end
            S_LOAD: begin
                addr_d = addr_q + ADDR_W'(1);
                if (col_end) begin
                    col_d = '0;
                    if (lrow_q == KI_W'(K - 1)) begin
                        lrow_d  = '0;
                        state_d = S_EMIT;
                    end else begin
                        lrow_d = lrow_q + KI_W'(1);
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            S_SHIFT: begin
                addr_d = addr_q + ADDR_W'(1);
                if (col_end) begin
                    col_d   = '0;
                    state_d = S_EMIT;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (tj_q != KI_W'(K - 1)) begin
                        tj_d = tj_q + KI_W'(1);
                    end else begin
                        tj_d = '0;
                        if (ti_q != KI_W'(K - 1)) begin
                            ti_d = ti_q + KI_W'(1);
                        end else begin
                            ti_d = '0;
                            // Addresses run sequentially, so the next row or
                            // next channel base is already in addr_q here.
                            if (!last_row) begin
                                row_d    = row_q + ROW_W'(1);
                                shift_up = 1'b1;
                                state_d  = S_SHIFT;
                            end else if (!last_ch) begin
                                ch_d    = ch_q + CH_W'(1);
                                row_d   = '0;
                                state_d = S_LOAD;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enable) begin
            if (capture) begin
                line_q[wr_row][col_q] <= pixel_in;
            end
            if (shift_up) begin
                for (int n = 0; n < K - 1; n++) begin
                    line_q[KI_W'(n)] <= line_q[KI_W'(n + 1)];
                end
            end
        end
    end

    genvar p;
    generate
        for (p = 0; p < OUT_W; p++) begin : g_pe
            logic [COL_W-1:0] col_sel;
            assign col_sel = COL_W'(p) + COL_W'(tj_q);
            assign out_kernel_port[(OUT_W-p)*DATA_W-1 -: DATA_W] =
                out_valid ? line_q[ti_q][col_sel] : '0;
        end
    endgenerate

    assign out_valid = (state_q == S_EMIT);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign rom_addr  = addr_q;
    assign out_tap   = out_valid ? TAP_W'(int'(ti_q) * K + int'(tj_q)) : '0;
    assign out_row   = out_valid ? row_q : '0;
    assign out_ch    = out_valid ? ch_q : '0;
    assign out_last  = out_valid & last_tap & last_row & last_ch;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_window_streamer: directed bench, default / CH=2 / 3x3 instances   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_conv_window_streamer;

    typedef struct {
        int tap; int row; int ch; bit last; logic [191:0] slice; int cyc;
    } hs_t;

    typedef struct {
        int hs; int tap; int row; int ch; int first; bit last;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, en, rdy, st_a, st_b, st_c;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    // instance A: defaults
    logic [5:0]   addr_a;
    logic [191:0] kern_a;
    logic [3:0]   tap_a;
    logic [2:0]   row_a;
    logic [0:0]   ch_a;
    logic         v_a, last_a, busy_a, done_a;
    // instance B: two channels
    logic [6:0]   addr_b;
    logic [191:0] kern_b;
    logic [3:0]   tap_b;
    logic [2:0]   row_b;
    logic [0:0]   ch_b;
    logic         v_b, last_b, busy_b, done_b;
    // instance C: 3x3 image, 3x3 kernel
    logic [5:0]   addr_c;
    logic [31:0]  kern_c;
    logic [3:0]   tap_c;
    logic [0:0]   row_c;
    logic [0:0]   ch_c;
    logic         v_c, last_c, busy_c, done_c;

    hs_t hs_a[$], hs_b[$], hs_c[$];
    hs_t ra, rb, rc;
    int  sa, sb, sc, dcnt_a, dcnt_b, dcnt_c, dlat_a, dlat_c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_window_streamer u_a (
        .clk(clk), .rst_n(rst_n), .enable(en), .start(st_a),
        .pixel_in({26'd0, addr_a}), .rom_addr(addr_a), .out_kernel_port(kern_a),
        .out_valid(v_a), .out_ready(rdy), .out_tap(tap_a), .out_row(row_a),
        .out_ch(ch_a), .out_last(last_a), .busy(busy_a), .done(done_a));

    conv_window_streamer #(.CH(2), .ADDR_W(7)) u_b (
        .clk(clk), .rst_n(rst_n), .enable(en), .start(st_b),
        .pixel_in({25'd0, addr_b}), .rom_addr(addr_b), .out_kernel_port(kern_b),
        .out_valid(v_b), .out_ready(rdy), .out_tap(tap_b), .out_row(row_b),
        .out_ch(ch_b), .out_last(last_b), .busy(busy_b), .done(done_b));

    conv_window_streamer #(.IMG_W(3), .IMG_H(3), .K(3)) u_c (
        .clk(clk), .rst_n(rst_n), .enable(en), .start(st_c),
        .pixel_in({26'd0, addr_c}), .rom_addr(addr_c), .out_kernel_port(kern_c),
        .out_valid(v_c), .out_ready(rdy), .out_tap(tap_c), .out_row(row_c),
        .out_ch(ch_c), .out_last(last_c), .busy(busy_c), .done(done_c));

    // Handshake / start / done monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n && en && st_a && !busy_a) sa = cyc + 1;
        if (rst_n && en && v_a && rdy) begin
            ra.tap = int'(tap_a); ra.row = int'(row_a); ra.ch = int'(ch_a);
            ra.last = last_a; ra.slice = kern_a; ra.cyc = cyc;
            hs_a.push_back(ra);
        end
        if (done_a) begin dcnt_a++; dlat_a = cyc - sa; end
    end

    always @(negedge clk) begin
        if (rst_n && en && st_b && !busy_b) sb = cyc + 1;
        if (rst_n && en && v_b && rdy) begin
            rb.tap = int'(tap_b); rb.row = int'(row_b); rb.ch = int'(ch_b);
            rb.last = last_b; rb.slice = kern_b; rb.cyc = cyc;
            hs_b.push_back(rb);
        end
        if (done_b) dcnt_b++;
    end

    always @(negedge clk) begin
        if (rst_n && en && st_c && !busy_c) sc = cyc + 1;
        if (rst_n && en && v_c && rdy) begin
            rc.tap = int'(tap_c); rc.row = int'(row_c); rc.ch = int'(ch_c);
            rc.last = last_c; rc.slice = {160'd0, kern_c}; rc.cyc = cyc;
            hs_c.push_back(rc);
        end
        if (done_c) begin dcnt_c++; dlat_c = cyc - sc; end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got timeout, want event", nm);
    endtask

    // PE 0 occupies the MSB slice; PE p carries first+p
    function automatic logic [191:0] mk_slice(input int first, input int npe);
        logic [191:0] s = '0;
        for (int p = 0; p < npe; p++) s[(npe-p)*32-1 -: 32] = 32'(first + p);
        return s;
    endfunction

    task automatic check_seq(input string tag, input hs_t q[$], input int img_w,
                             input int k, input int out_h, input int ch_n);
        int n, npe, img_h;
        n = ch_n * out_h * k * k;
        npe = img_w - k + 1;
        img_h = out_h + k - 1;
        chk({tag, " count"}, q.size(), n);
        for (int x = 0; x < q.size() && x < n; x++) begin
            int c, rm, r, t, first, et, at;
            logic [191:0] es;
            c = x / (out_h * k * k);
            rm = x % (out_h * k * k);
            r = rm / (k * k);
            t = rm % (k * k);
            first = c * img_h * img_w + (r + t / k) * img_w + t % k;
            es = mk_slice(first, npe);
            et = t * 1000 + r * 100 + c * 10 + ((x == n - 1) ? 1 : 0);
            at = q[x].tap * 1000 + q[x].row * 100 + q[x].ch * 10 + (q[x].last ? 1 : 0);
            n_vec++;
            if (at != et || q[x].slice !== es) begin
                n_bad++;
                $display("FAIL %s hs%0d: got tags %0d slice %0h, want tags %0d slice %0h",
                         tag, x, at, q[x].slice, et, es);
            end
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, " kern"}, kern_a, 0);
        chk({tag, " valid"}, v_a, 0);
        chk({tag, " busy"}, busy_a, 0);
        chk({tag, " done"}, done_a, 0);
        chk({tag, " addr"}, addr_a, 0);
        chk({tag, " tags"}, {tap_a, row_a, ch_a, last_a}, 0);
    endtask

    task automatic start_a();
        hs_a.delete();
        dcnt_a = 0;
        st_a = 1'b1;
        step(1);
        st_a = 1'b0;
    endtask

    task automatic wait_valid_a(input string nm);
        for (int w = 0; w < 100 && !v_a; w++) step(1);
        if (!v_a) tmo(nm);
    endtask

    task automatic wait_done_a(input string nm);
        for (int w = 0; w < 400 && dcnt_a == 0; w++) step(1);
        if (dcnt_a == 0) tmo(nm);
        step(2);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{hs: 0,  tap: 0, row: 0, ch: 0, first: 0,  last: 1'b0};
        tbl[1] = '{hs: 4,  tap: 4, row: 0, ch: 0, first: 9,  last: 1'b0};
        tbl[2] = '{hs: 5,  tap: 5, row: 0, ch: 0, first: 10, last: 1'b0};
        tbl[3] = '{hs: 9,  tap: 0, row: 1, ch: 0, first: 8,  last: 1'b0};
        tbl[4] = '{hs: 17, tap: 8, row: 1, ch: 0, first: 26, last: 1'b0};
        tbl[5] = '{hs: 30, tap: 3, row: 3, ch: 0, first: 32, last: 1'b0};
        tbl[6] = '{hs: 53, tap: 8, row: 5, ch: 0, first: 58, last: 1'b1};

        rst_n = 1'b0; en = 1'b1; rdy = 1'b1; st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
        dcnt_a = 0; dcnt_b = 0; dcnt_c = 0; sa = 0; sb = 0; sc = 0;
        step(3);
        chk_idle_a("reset");
        rst_n = 1'b1;
        step(1);

        // 1: plain frame
        start_a();
        wait_valid_a("t1 first valid");
        chk("t1 first valid latency", cyc - sa, 24);
        wait_done_a("t1 done");
        chk("t1 done latency", dlat_a, 119);
        chk("t1 done pulses", dcnt_a, 1);
        chk("t1 busy after done", busy_a, 0);
        for (int k = 0; k < 7; k++) begin
            if (tbl[k].hs < hs_a.size()) begin
                chk($sformatf("t1 vec%0d slice", k), hs_a[tbl[k].hs].slice, mk_slice(tbl[k].first, 6));
                chk($sformatf("t1 vec%0d tags", k),
                    {8'(hs_a[tbl[k].hs].tap), 8'(hs_a[tbl[k].hs].row), 8'(hs_a[tbl[k].hs].ch), 1'(hs_a[tbl[k].hs].last)},
                    {8'(tbl[k].tap), 8'(tbl[k].row), 8'(tbl[k].ch), 1'(tbl[k].last)});
            end else begin
                chk($sformatf("t1 vec%0d present", k), hs_a.size(), tbl[k].hs + 1);
            end
        end
        check_seq("t1", hs_a, 8, 3, 6, 1);

        // 2: backpressure on tap 4
        start_a();
        for (int w = 0; w < 100 && !(v_a && tap_a == 4'd4); w++) step(1);
        if (!(v_a && tap_a == 4'd4)) tmo("t2 tap4");
        rdy = 1'b0;
        for (int h = 0; h < 5; h++) begin
            step(1);
            chk($sformatf("t2 hold%0d slice", h), kern_a, mk_slice(9, 6));
            chk($sformatf("t2 hold%0d tags", h), {v_a, tap_a, row_a}, {1'b1, 4'd4, 3'd0});
        end
        rdy = 1'b1;
        wait_done_a("t2 done");
        chk("t2 done latency", dlat_a, 124);
        check_seq("t2", hs_a, 8, 3, 6, 1);

        // 3: enable freeze in LOAD, then in EMIT
        start_a();
        for (int w = 0; w < 50 && addr_a != 6'd10; w++) step(1);
        if (addr_a != 6'd10) tmo("t3 addr10");
        en = 1'b0;
        for (int h = 0; h < 3; h++) begin
            step(1);
            chk($sformatf("t3 freeze%0d addr", h), addr_a, 10);
        end
        en = 1'b1;
        wait_valid_a("t3 first valid");
        chk("t3 first valid latency", cyc - sa, 27);
        chk("t3 first slice", kern_a, mk_slice(0, 6));
        for (int w = 0; w < 20 && !(v_a && tap_a == 4'd2); w++) step(1);
        en = 1'b0;
        for (int h = 0; h < 2; h++) begin
            step(1);
            chk($sformatf("t3 emit freeze%0d", h), {v_a, tap_a}, {1'b1, 4'd2});
        end
        en = 1'b1;
        wait_done_a("t3 done");
        chk("t3 done latency", dlat_a, 124);
        check_seq("t3", hs_a, 8, 3, 6, 1);

        // 4: two channels
        hs_b.delete();
        dcnt_b = 0;
        st_b = 1'b1;
        step(1);
        st_b = 1'b0;
        for (int w = 0; w < 600 && dcnt_b == 0; w++) step(1);
        if (dcnt_b == 0) tmo("t4 done");
        step(3);
        chk("t4 done pulses", dcnt_b, 1);
        check_seq("t4", hs_b, 8, 3, 6, 2);
        if (hs_b.size() == 108) begin
            int nl = 0;
            chk("t4 ch1 tap0 slice", hs_b[54].slice, mk_slice(64, 6));
            chk("t4 ch1 tap0 tags", {8'(hs_b[54].tap), 8'(hs_b[54].row), 8'(hs_b[54].ch)}, {8'd0, 8'd0, 8'd1});
            chk("t4 final slice", hs_b[107].slice, mk_slice(122, 6));
            foreach (hs_b[x]) if (hs_b[x].last) nl++;
            chk("t4 last count", nl, 1);
        end

        // 5: reset while emitting row 2
        start_a();
        for (int w = 0; w < 100 && !(v_a && row_a == 3'd2); w++) step(1);
        if (!(v_a && row_a == 3'd2)) tmo("t5 row2");
        rst_n = 1'b0;
        step(1);
        chk_idle_a("t5 after reset");
        rst_n = 1'b1;
        step(5);
        chk("t5 no done", dcnt_a, 0);
        start_a();
        wait_done_a("t5 done");
        if (hs_a.size() > 0) chk("t5 restart slice", hs_a[0].slice, mk_slice(0, 6));
        chk("t5 done latency", dlat_a, 119);
        check_seq("t5", hs_a, 8, 3, 6, 1);

        // 6: K = IMG_W = IMG_H = 3, start pulse while busy
        hs_c.delete();
        dcnt_c = 0;
        st_c = 1'b1;
        step(1);
        st_c = 1'b0;
        for (int w = 0; w < 50 && hs_c.size() < 3; w++) step(1);
        chk("t6 busy mid-frame", busy_c, 1);
        st_c = 1'b1;
        step(1);
        st_c = 1'b0;
        for (int w = 0; w < 100 && dcnt_c == 0; w++) step(1);
        if (dcnt_c == 0) tmo("t6 done");
        step(3);
        chk("t6 done latency", dlat_c, 19);
        chk("t6 done pulses", dcnt_c, 1);
        chk("t6 busy after done", busy_c, 0);
        check_seq("t6", hs_c, 3, 3, 1, 1);
        for (int x = 1; x < hs_c.size(); x++)
            chk($sformatf("t6 gap hs%0d", x), hs_c[x].cyc - hs_c[x-1].cyc, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
